// File: rtl/factor_search_ctrl.sv
// factor_search_ctrl: walks candidate pairs 2 <= i1 <= i2 <= 2^W-1 one per cycle through a
// W x W multiply-compare and streams every pair whose product equals the captured target.
module factor_search_ctrl #(
  parameter int W  = 4,
  parameter int CW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [2*W-1:0]  target,
  output logic            busy,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [W-1:0]    res_i1,
  output logic [W-1:0]    res_i2,
  output logic            done,
  output logic            none_found,
  output logic [CW-1:0]   pair_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_HOLD   = 2'd2,
    S_FIN    = 2'd3
  } state_t;

  localparam logic [W-1:0]    I_MAX   = {W{1'b1}};
  localparam logic [W-1:0]    I_INIT  = W'(2);
  localparam logic [2*W-1:0]  T_MIN   = (2*W)'(4);
  localparam logic [CW-1:0]   CNT_MAX = {CW{1'b1}};

  state_t           r_state, w_state_nxt;
  logic [W-1:0]     r_i1, r_i2, w_i1_nxt, w_i2_nxt;
  logic [2*W-1:0]   r_tgt, w_tgt_nxt;
  logic [W-1:0]     r_res_i1, r_res_i2, w_res_i1_nxt, w_res_i2_nxt;
  logic             r_res_valid, w_res_valid_nxt;
  logic [CW-1:0]    r_pair_cnt, w_pair_cnt_nxt;
  logic             r_none_found, w_none_found_nxt;
  logic             r_done, r_busy;
  logic [2*W-1:0]   w_p, w_sq;
  logic             w_row_end, w_adv_fin;
  logic [W-1:0]     w_adv_i1, w_adv_i2;

  assign w_p       = {{W{1'b0}}, r_i1} * {{W{1'b0}}, r_i2};
  assign w_sq      = {{W{1'b0}}, r_i1} * {{W{1'b0}}, r_i1};
  assign w_row_end = (w_p > r_tgt) || (r_i2 == I_MAX);

  // Next candidate after a non-matching cycle or a consumed match: column step, row step or end
  always_comb begin
    w_adv_fin = 1'b0;
    w_adv_i1  = r_i1;
    w_adv_i2  = r_i2;
    if (w_row_end) begin
      if (r_i1 == I_MAX) begin
        w_adv_fin = 1'b1;
      end else begin
        w_adv_i1 = r_i1 + W'(1);
        w_adv_i2 = r_i1 + W'(1);
      end
    end else begin
      w_adv_i2 = r_i2 + W'(1);
    end
  end

  // Next-state and next-register logic
  always_comb begin
    w_state_nxt      = r_state;
    w_i1_nxt         = r_i1;
    w_i2_nxt         = r_i2;
    w_tgt_nxt        = r_tgt;
    w_res_i1_nxt     = r_res_i1;
    w_res_i2_nxt     = r_res_i2;
    w_res_valid_nxt  = r_res_valid;
    w_pair_cnt_nxt   = r_pair_cnt;
    w_none_found_nxt = r_none_found;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_tgt_nxt        = target;
          w_i1_nxt         = I_INIT;
          w_i2_nxt         = I_INIT;
          w_pair_cnt_nxt   = {CW{1'b0}};
          w_none_found_nxt = 1'b0;
          w_state_nxt      = (target < T_MIN) ? S_FIN : S_SEARCH;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SEARCH: begin
        if (abort) begin
          w_res_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end else if (w_sq > r_tgt) begin
          w_state_nxt = S_FIN;
        end else if (w_p == r_tgt) begin
          w_res_i1_nxt    = r_i1;
          w_res_i2_nxt    = r_i2;
          w_res_valid_nxt = 1'b1;
          w_state_nxt     = S_HOLD;
        end else if (w_adv_fin) begin
          w_state_nxt = S_FIN;
        end else begin
          w_i1_nxt = w_adv_i1;
          w_i2_nxt = w_adv_i2;
        end
      end
      S_HOLD: begin
        if (abort) begin
          w_res_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end else if (r_res_valid && res_ready) begin
          w_res_valid_nxt = 1'b0;
          w_pair_cnt_nxt  = (r_pair_cnt == CNT_MAX) ? r_pair_cnt : r_pair_cnt + CW'(1);
          w_i1_nxt        = w_adv_i1;
          w_i2_nxt        = w_adv_i2;
          w_state_nxt     = w_adv_fin ? S_FIN : S_SEARCH;
        end else begin
          w_state_nxt = S_HOLD;
        end
      end
      S_FIN: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    // none_found is qualified on FIN entry so it is valid together with done
    if (w_state_nxt == S_FIN) begin
      w_none_found_nxt = (w_pair_cnt_nxt == {CW{1'b0}});
    end else begin
      w_none_found_nxt = w_none_found_nxt;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and registered output flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i1         <= I_INIT;
      r_i2         <= I_INIT;
      r_tgt        <= {(2*W){1'b0}};
      r_res_i1     <= {W{1'b0}};
      r_res_i2     <= {W{1'b0}};
      r_res_valid  <= 1'b0;
      r_pair_cnt   <= {CW{1'b0}};
      r_none_found <= 1'b0;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_i1         <= w_i1_nxt;
      r_i2         <= w_i2_nxt;
      r_tgt        <= w_tgt_nxt;
      r_res_i1     <= w_res_i1_nxt;
      r_res_i2     <= w_res_i2_nxt;
      r_res_valid  <= w_res_valid_nxt;
      r_pair_cnt   <= w_pair_cnt_nxt;
      r_none_found <= w_none_found_nxt;
      r_done       <= (w_state_nxt == S_FIN);
      r_busy       <= (w_state_nxt == S_SEARCH) || (w_state_nxt == S_HOLD);
    end
  end

  assign busy       = r_busy;
  assign res_valid  = r_res_valid;
  assign res_i1     = r_res_i1;
  assign res_i2     = r_res_i2;
  assign done       = r_done;
  assign none_found = r_none_found;
  assign pair_cnt   = r_pair_cnt;

endmodule

// File: tb/tb_factor_search_ctrl.sv
// Bench for factor_search_ctrl: table of known targets, hand-written corner sequences,
// then random targets with random back-pressure checked against a brute-force factor list.
module tb_factor_search_ctrl;
  localparam int W  = 4;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst_n, start, abort, res_ready;
  logic [2*W-1:0]  target;
  logic            busy, res_valid, done, none_found;
  logic [W-1:0]    res_i1, res_i2;
  logic [CW-1:0]   pair_cnt;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  bit         g_done;
  logic       g_nf;
  logic [CW-1:0] g_cnt;
  int         g_first_valid;
  int         g_done_idx;

  typedef struct {
    logic [7:0]  t;
    logic [31:0] pairs;
    int          n;
    int          first_v;
    int          done_idx;
  } vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;

  factor_search_ctrl #(.W(W), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .target(target),
    .busy(busy), .res_valid(res_valid), .res_ready(res_ready), .res_i1(res_i1),
    .res_i2(res_i2), .done(done), .none_found(none_found), .pair_cnt(pair_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // All factor pairs inside the operand range, in row-major order
  function automatic void model(input logic [7:0] t);
    exp_q.delete();
    for (int a = 2; a < 16; a++)
      for (int b = a; b < 16; b++)
        if (a * b == int'(t)) exp_q.push_back({4'(a), 4'(b)});
  endfunction

  task automatic collect(input bit rnd);
    logic [3:0] pi1, pi2;
    bit pv, prdy, busy_bad;
    pv = 1'b0; prdy = 1'b0; pi1 = 4'd0; pi2 = 4'd0; busy_bad = 1'b0;
    got_q.delete();
    g_done = 1'b0; g_first_valid = -1; g_done_idx = -1;
    for (int c = 0; c < 3000; c++) begin
      if (done) begin
        g_done = 1'b1; g_nf = none_found; g_cnt = pair_cnt; g_done_idx = c;
        break;
      end
      if (busy !== 1'b1) busy_bad = 1'b1;
      if (pv && !prdy) check("hold_stable", {res_valid, res_i1, res_i2}, {1'b1, pi1, pi2});
      if (res_valid && g_first_valid < 0) g_first_valid = c;
      res_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rnd) begin
        start  = 1'($urandom_range(0, 1));
        target = 8'($urandom);
      end
      if (res_valid && res_ready) got_q.push_back({res_i1, res_i2});
      pv = res_valid; prdy = res_ready; pi1 = res_i1; pi2 = res_i2;
      tick();
    end
    start = 1'b0;
    res_ready = 1'b0;
    check("busy_during_search", {31'd0, busy_bad}, 32'd0);
  endtask

  task automatic run_search(input logic [7:0] t, input bit rnd);
    target = t; start = 1'b1; res_ready = 1'b0;
    tick();
    start = 1'b0;
    collect(rnd);
  endtask

  task automatic check_result(input string tag);
    int n;
    n = exp_q.size();
    check({tag, "_done_seen"}, {31'd0, g_done}, 32'd1);
    check({tag, "_npairs"}, got_q.size(), n);
    for (int k = 0; k < n && k < got_q.size(); k++)
      check({tag, "_pair"}, {24'd0, got_q[k]}, {24'd0, exp_q[k]});
    check({tag, "_none_found"}, {31'd0, g_nf}, {31'd0, (n == 0)});
    check({tag, "_pair_cnt"}, {28'd0, g_cnt}, (n > 15) ? 32'd15 : n);
    tick();
    check({tag, "_done_fell"}, {30'd0, done, busy}, 32'd0);
    check({tag, "_held"}, {27'd0, none_found, pair_cnt}, {27'd0, g_nf, g_cnt});
  endtask

  task automatic wait_valid(input string name);
    int k;
    k = 0;
    while (!res_valid && k < 400) begin
      tick();
      k++;
    end
    check(name, {31'd0, res_valid}, 32'd1);
  endtask

  initial begin
    logic [31:0] pk;
    vecs[0] = '{8'd35,  32'h5700_0000, 1, -2, -2};
    vecs[1] = '{8'd36,  32'h3C49_6600, 3, -2, -2};
    vecs[2] = '{8'd13,  32'h0000_0000, 0, -1, 10};
    vecs[3] = '{8'd225, 32'hFF00_0000, 1, -2, -2};
    vecs[4] = '{8'd1,   32'h0000_0000, 0, -1, 0};
    vecs[5] = '{8'd4,   32'h2200_0000, 1, 1, 4};
    vecs[6] = '{8'd16,  32'h2844_0000, 2, -2, -2};
    vecs[7] = '{8'd3,   32'h0000_0000, 0, -1, 0};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; res_ready = 1'b0; target = 8'd0;
    #12;
    rst_n = 1'b1;
    tick();
    check("reset_outputs", {res_i1, res_i2, pair_cnt, busy, res_valid, done, none_found}, 32'd0);

    for (int v = 0; v < 8; v++) begin
      exp_q.delete();
      pk = vecs[v].pairs;
      for (int k = 0; k < vecs[v].n; k++) exp_q.push_back(pk[31 - 8*k -: 8]);
      run_search(vecs[v].t, 1'b0);
      if (vecs[v].first_v != -2) check("first_valid_cycle", g_first_valid, vecs[v].first_v);
      if (vecs[v].done_idx != -2) check("done_cycle", g_done_idx, vecs[v].done_idx);
      check_result("table");
    end

    // Back-pressure: first pair held for 10 cycles
    target = 8'd36; start = 1'b1; res_ready = 1'b0;
    tick();
    start = 1'b0;
    target = 8'd35;
    wait_valid("bp_first_valid");
    check("bp_first_pair", {24'd0, res_i1, res_i2}, 32'h3C);
    for (int k = 0; k < 10; k++) begin
      tick();
      check("bp_stable", {res_valid, busy, res_i1, res_i2}, {2'b11, 4'd3, 4'd12});
    end
    collect(1'b0);
    model(8'd36);
    check_result("bp");

    // Abort in HOLD together with a handshake: abort wins, count stays at 1
    target = 8'd36; start = 1'b1; res_ready = 1'b0;
    tick();
    start = 1'b0;
    wait_valid("ab_valid1");
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    wait_valid("ab_valid2");
    check("ab_second_pair", {24'd0, res_i1, res_i2}, 32'h49);
    abort = 1'b1; res_ready = 1'b1;
    tick();
    abort = 1'b0; res_ready = 1'b0;
    check("ab_idle", {29'd0, busy, res_valid, done}, 32'd0);
    check("ab_cnt", {28'd0, pair_cnt}, 32'd1);
    tick();
    check("ab_no_done", {30'd0, done, busy}, 32'd0);
    model(8'd35);
    run_search(8'd35, 1'b0);
    check_result("after_abort");

    // Asynchronous reset while a pair is pending
    target = 8'd36; start = 1'b1; res_ready = 1'b0;
    tick();
    start = 1'b0;
    wait_valid("rst_valid");
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset", {res_i1, res_i2, pair_cnt, busy, res_valid, done, none_found}, 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    check("post_reset_idle", {30'd0, busy, res_valid}, 32'd0);

    // Random targets under random back-pressure and start/target noise
    for (int r = 0; r < 40; r++) begin
      logic [7:0] t;
      t = (r % 3 == 0) ? 8'(($urandom_range(2, 15)) * ($urandom_range(2, 15))) : 8'($urandom);
      model(t);
      run_search(t, 1'b1);
      check_result("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
